// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between the scanout fetcher and a CPU requester.
// Optional stall statistics are enabled by defining ARB_STATS_EN (adds cpu_stall_count).
module vram_arbiter #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned H_SCALE_LOG2 = 2,
  parameter int unsigned V_SCALE_LOG2 = 1,
  parameter int unsigned SRC_WIDTH    = 160,
  parameter int unsigned SRC_HEIGHT   = 192,
  parameter logic [6:0]  BORDER_COLOR = 7'h00,
  parameter int unsigned ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  in_image,
  output logic [6:0]            color,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  vram_we,
  output logic [7:0]            vram_wdata,
  input  logic [7:0]            vram_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]           cpu_stall_count
`endif
);

  localparam int unsigned SLOT_W = H_SCALE_LOG2;
  localparam int unsigned GROUP  = 32'd1 << H_SCALE_LOG2;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_e;

  state_e                state_q, state_d;
  logic [6:0]            color_q, color_d;
  logic [6:0]            prefetch_q, prefetch_d;
  logic                  fetch_q, fetch_d;
  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic                  vram_we_q, vram_we_d;
  logic [7:0]            vram_wdata_q, vram_wdata_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic [7:0]            cpu_rdata_q, cpu_rdata_d;

  logic [SLOT_W-1:0]     slot;
  logic [31:0]           h32, v32, nv32, sl, nsl, col, nh32, nvl, n_sl, n_col;
  logic                  last_h, due_col, due_wrap, fetch_due, next_vis;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  // Display schedule: which slot-0 cycles fetch, and what the next source pixel will be.
  always_comb begin
    h32        = 32'(hpos);
    v32        = 32'(vpos);
    slot       = hpos[SLOT_W-1:0];
    sl         = v32 >> V_SCALE_LOG2;
    nv32       = (v32 == V_TOTAL - 1) ? 32'd0 : v32 + 32'd1;
    nsl        = nv32 >> V_SCALE_LOG2;
    col        = (h32 >> H_SCALE_LOG2) + 32'd1;
    last_h     = (h32 == H_TOTAL - 1);
    due_col    = (slot == '0) && (col < SRC_WIDTH) && (sl < SRC_HEIGHT);
    due_wrap   = (slot == '0) && (h32 == H_TOTAL - GROUP) && (nsl < SRC_HEIGHT);
    fetch_due  = due_col || due_wrap;
    fetch_addr = due_col ? ADDR_WIDTH'(sl * SRC_WIDTH + col) : ADDR_WIDTH'(nsl * SRC_WIDTH);
    nh32       = last_h ? 32'd0 : h32 + 32'd1;
    nvl        = last_h ? nv32 : v32;
    // in_image only describes the current line, so the line-wrap case uses V_ACTIVE
    next_vis   = last_h ? (nv32 < V_ACTIVE) : (in_image && (nh32 < H_ACTIVE));
    n_sl       = nvl >> V_SCALE_LOG2;
    n_col      = nh32 >> H_SCALE_LOG2;
  end

  // Next-state and output logic: display fetch first, CPU FSM only in free slots.
  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    prefetch_d   = prefetch_q;
    fetch_d      = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_we_d    = 1'b0;
    vram_wdata_d = vram_wdata_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;

    if (fetch_due) begin
      vram_addr_d = fetch_addr;
      fetch_d     = 1'b1;
    end

    if (fetch_q && (slot == SLOT_W'(1))) begin
      prefetch_d = vram_rdata[6:0];
    end

    if (&slot) begin
      if (!next_vis) begin
        color_d = 7'h00;
      end else if ((n_sl < SRC_HEIGHT) && (n_col < SRC_WIDTH)) begin
        color_d = prefetch_q;
      end else begin
        color_d = BORDER_COLOR;
      end
    end

    case (state_q)
      IDLE: begin
        if (cpu_req && !fetch_due) begin
          vram_addr_d  = cpu_addr;
          vram_we_d    = cpu_we;
          vram_wdata_d = cpu_wdata;
          state_d      = ACK;
        end
      end
      ACK: begin
        cpu_ack_d = 1'b1;
        if (!vram_we_q) begin
          cpu_rdata_d = vram_rdata;
        end
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      color_q      <= 7'h00;
      prefetch_q   <= 7'h00;
      fetch_q      <= 1'b0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= 8'h00;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      prefetch_q   <= prefetch_d;
      fetch_q      <= fetch_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign color      = color_q;
  assign vram_addr  = vram_addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;

`ifdef ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of requests held off by a due display slot; cleared at frame origin.
  always_comb begin
    stall_d = stall_q;
    if ((hpos == '0) && (vpos == '0)) begin
      stall_d = 16'h0000;
    end else if ((state_q == IDLE) && cpu_req && fetch_due && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= 16'h0000;
    else       stall_q <= stall_d;
  end

  assign cpu_stall_count = stall_q;
`endif

endmodule
